// File: rtl/interval_pkg.sv
// interval_pkg: shared types and constants for the interval timer.
//   phase_t     - 3-bit phase encoding driven on interval_timer.phase
//   PREP_SEC    - countdown length of the optional PREP phase
//   SEC_W_DEF   - default width of second counters
//   ROUND_W_DEF - default width of the round counter
package interval_pkg;

  localparam int SEC_W_DEF   = 8;
  localparam int ROUND_W_DEF = 5;
  localparam int PREP_SEC    = 3;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_PREP   = 3'd1,
    PH_WORK   = 3'd2,
    PH_REST   = 3'd3,
    PH_PAUSED = 3'd4,
    PH_DONE   = 3'd5
  } phase_t;

endpackage

// File: rtl/level_edge_sync.sv
// level_edge_sync: brings an asynchronous level into the clk domain with a
// two-flop synchronizer and produces a registered one-cycle pulse on each
// rising edge of the synchronized level.
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   level_in   in  asynchronous level
//   level_sync out synchronized level (two flops after level_in)
//   rise_pulse out one-cycle pulse, high 3 cycles after level_in rises
module level_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  output logic level_sync,
  output logic rise_pulse
);

  logic meta_reg;
  logic sync_reg;
  logic sync_d_reg;
  logic rise_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      sync_d_reg <= 1'b0;
      rise_reg   <= 1'b0;
    end else begin
      meta_reg   <= level_in;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
      // Cleared history means a level already high at reset release
      // yields a single pulse.
      rise_reg   <= sync_reg & ~sync_d_reg;
    end
  end

  assign level_sync = sync_reg;
  assign rise_pulse = rise_reg;

endmodule

// File: rtl/interval_timer.sv
// interval_timer: work/rest interval session sequencer for the training
// scheduler. The divider's 1 Hz and 2 kHz square waves are sampled as data.
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   clk_1hz_in  in  1 Hz level, rising edge = one second tick
//   clk_2khz_in in  2 kHz level, gated onto buzzer
//   start       in  pulse: latch config, begin session (IDLE/DONE only)
//   pause       in  pulse: toggle running <-> PAUSED
//   abort       in  pulse: return to IDLE
//   work_sec    in  work interval seconds
//   rest_sec    in  rest interval seconds, 0 = no rest
//   num_rounds  in  number of work intervals
//   phase       out current phase_t encoding
//   sec_left    out seconds remaining in current phase
//   round_idx   out 1-based round, 0 in IDLE
//   buzzer      out gated 2 kHz tone
//   done        out one-cycle pulse on entry to DONE
// Build option: define INTERVAL_PREP_EN to add a 3 s PREP countdown before
// the first WORK phase.
module interval_timer
  import interval_pkg::*;
#(
  parameter int SEC_W    = SEC_W_DEF,
  parameter int ROUND_W  = ROUND_W_DEF,
  parameter int BEEP_SEC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_1hz_in,
  input  logic               clk_2khz_in,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [SEC_W-1:0]   work_sec,
  input  logic [SEC_W-1:0]   rest_sec,
  input  logic [ROUND_W-1:0] num_rounds,
  output logic [2:0]         phase,
  output logic [SEC_W-1:0]   sec_left,
  output logic [ROUND_W-1:0] round_idx,
  output logic               buzzer,
  output logic               done
);

  localparam int BEEP_W = (BEEP_SEC < 1) ? 1 : $clog2(BEEP_SEC + 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_SEC);

  logic tick_1s;
  logic hz_level_unused;
  logic khz_sync;
  logic khz_rise_unused;

  level_edge_sync u_sync_1hz (
    .clk        (clk),
    .rst_n      (rst_n),
    .level_in   (clk_1hz_in),
    .level_sync (hz_level_unused),
    .rise_pulse (tick_1s)
  );

  level_edge_sync u_sync_2khz (
    .clk        (clk),
    .rst_n      (rst_n),
    .level_in   (clk_2khz_in),
    .level_sync (khz_sync),
    .rise_pulse (khz_rise_unused)
  );

  phase_t             phase_reg;
  phase_t             ret_phase_reg;
  logic [SEC_W-1:0]   sec_reg;
  logic [ROUND_W-1:0] round_reg;
  logic [BEEP_W-1:0]  beep_reg;
  logic               done_reg;
  logic [SEC_W-1:0]   work_cfg_reg;
  logic [SEC_W-1:0]   rest_cfg_reg;
  logic [ROUND_W-1:0] rounds_cfg_reg;

  logic [BEEP_W-1:0]  beep_next;
  logic               start_ok;

  assign beep_next = (beep_reg != '0) ? beep_reg - BEEP_W'(1) : beep_reg;
  assign start_ok  = (work_sec != '0) && (num_rounds != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg      <= PH_IDLE;
      ret_phase_reg  <= PH_IDLE;
      sec_reg        <= '0;
      round_reg      <= '0;
      beep_reg       <= '0;
      done_reg       <= 1'b0;
      work_cfg_reg   <= '0;
      rest_cfg_reg   <= '0;
      rounds_cfg_reg <= '0;
    end else if (abort) begin
      // Configuration survives an abort so a later start may reuse it.
      phase_reg     <= PH_IDLE;
      ret_phase_reg <= PH_IDLE;
      sec_reg       <= '0;
      round_reg     <= '0;
      beep_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (phase_reg)
        PH_IDLE, PH_DONE: begin
          if (tick_1s) beep_reg <= beep_next;
          if (start) begin
            work_cfg_reg   <= work_sec;
            rest_cfg_reg   <= rest_sec;
            rounds_cfg_reg <= num_rounds;
            if (start_ok) begin
`ifdef INTERVAL_PREP_EN
              phase_reg <= PH_PREP;
              sec_reg   <= SEC_W'(PREP_SEC);
              round_reg <= '0;
`else
              phase_reg <= PH_WORK;
              sec_reg   <= work_sec;
              round_reg <= ROUND_W'(1);
`endif
              beep_reg  <= BEEP_LOAD;
            end
          end
        end
`ifdef INTERVAL_PREP_EN
        PH_PREP: begin
          if (pause) begin
            ret_phase_reg <= PH_PREP;
            phase_reg     <= PH_PAUSED;
          end else if (tick_1s) begin
            beep_reg <= beep_next;
            if (sec_reg > SEC_W'(1)) begin
              sec_reg <= sec_reg - SEC_W'(1);
            end else begin
              phase_reg <= PH_WORK;
              sec_reg   <= work_cfg_reg;
              round_reg <= ROUND_W'(1);
              beep_reg  <= BEEP_LOAD;
            end
          end
        end
`endif
        PH_WORK: begin
          if (pause) begin
            ret_phase_reg <= PH_WORK;
            phase_reg     <= PH_PAUSED;
          end else if (tick_1s) begin
            beep_reg <= beep_next;
            if (sec_reg > SEC_W'(1)) begin
              sec_reg <= sec_reg - SEC_W'(1);
            end else if (round_reg == rounds_cfg_reg) begin
              phase_reg <= PH_DONE;
              sec_reg   <= '0;
              done_reg  <= 1'b1;
              beep_reg  <= BEEP_LOAD;
            end else if (rest_cfg_reg != '0) begin
              phase_reg <= PH_REST;
              sec_reg   <= rest_cfg_reg;
              beep_reg  <= BEEP_LOAD;
            end else begin
              // No rest: roll straight into the next round, beeping again.
              round_reg <= round_reg + ROUND_W'(1);
              sec_reg   <= work_cfg_reg;
              beep_reg  <= BEEP_LOAD;
            end
          end
        end
        PH_REST: begin
          if (pause) begin
            ret_phase_reg <= PH_REST;
            phase_reg     <= PH_PAUSED;
          end else if (tick_1s) begin
            beep_reg <= beep_next;
            if (sec_reg > SEC_W'(1)) begin
              sec_reg <= sec_reg - SEC_W'(1);
            end else begin
              phase_reg <= PH_WORK;
              round_reg <= round_reg + ROUND_W'(1);
              sec_reg   <= work_cfg_reg;
              beep_reg  <= BEEP_LOAD;
            end
          end
        end
        PH_PAUSED: begin
          if (pause) phase_reg <= ret_phase_reg;
        end
        default: begin
          phase_reg <= PH_IDLE;
        end
      endcase
    end
  end

  assign phase     = phase_reg;
  assign sec_left  = sec_reg;
  assign round_idx = round_reg;
  assign done      = done_reg;
  assign buzzer    = khz_sync && (beep_reg != '0) && (phase_reg != PH_PAUSED);

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Consumes the divider's clk_1hz and clk_2khz outputs as plain data levels, never as clocks.
- Runs a work/rest interval session of N rounds for the training scheduler.
- Outputs the current phase, seconds remaining, round index, a gated 2 kHz buzzer drive and a done pulse for the display and sound stages.
- Single clock domain (clk).

Parameters:
- SEC_W, 8: width of second counters and of work_sec/rest_sec.
- ROUND_W, 5: width of round counter and of num_rounds.
- BEEP_SEC, 1: number of 1 s ticks the buzzer sounds after each phase entry.

Ports:
- clk  in  1  system clock, same clock as the divider.
- rst_n  in  1  reset: synchronous, active-low.
- clk_1hz_in  in  1  divider 1 Hz square wave, used as a level.
- clk_2khz_in  in  1  divider 2 kHz square wave, used as a level.
- start  in  1  one-cycle pulse; latches the configuration and starts a session.
- pause  in  1  one-cycle pulse; toggles between running and PAUSED.
- abort  in  1  one-cycle pulse; returns to IDLE.
- work_sec  in  SEC_W  work interval length in seconds.
- rest_sec  in  SEC_W  rest interval length in seconds; 0 means no rest.
- num_rounds  in  ROUND_W  number of work intervals.
- phase  out  3  IDLE=0, PREP=1, WORK=2, REST=3, PAUSED=4, DONE=5.
- sec_left  out  SEC_W  seconds remaining in the current phase.
- round_idx  out  ROUND_W  current round, 1-based; 0 in IDLE.
- buzzer  out  1  gated 2 kHz tone.
- done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - phase=IDLE, sec_left=0, round_idx=0, buzzer=0, done=0.
  - All sync/edge flops, latched config and the beep counter are cleared to 0.
- Tick generation:
  - Each level input passes through a 2-flop synchronizer and a rising-edge detector.
  - tick_1s is high for exactly 1 clk cycle, 3 cycles after clk_1hz_in rises.
  - The 2 kHz synced level drives the buzzer directly.
  - A level already high at reset release produces one tick; this is harmless in IDLE.
- IDLE:
  - On start, work_sec, rest_sec and num_rounds are latched.
  - If latched work_sec==0 or num_rounds==0, start is ignored and the block stays IDLE.
  - Otherwise: WORK, sec_left=work_sec, round_idx=1.
- WORK, on tick_1s:
  - sec_left>1: decrement.
  - sec_left==1 and round_idx==num_rounds: go to DONE, sec_left=0.
  - sec_left==1, otherwise, rest_sec!=0: go to REST, sec_left=rest_sec.
  - sec_left==1, otherwise, rest_sec==0: stay in WORK, round_idx+1, sec_left=work_sec.
- REST, on tick_1s:
  - sec_left>1: decrement.
  - sec_left==1: go to WORK, round_idx+1, sec_left=work_sec.
- PAUSED:
  - A pause pulse in WORK/REST/PREP enters PAUSED and stores the return phase.
  - sec_left, round_idx and the beep counter are frozen; tick_1s is ignored.
  - buzzer=0.
  - A second pause pulse returns to the stored phase with values unchanged.
- DONE:
  - done=1 for exactly the entry cycle.
  - The block holds in DONE; sec_left=0 and round_idx=num_rounds.
  - start relatches the config and begins a new session (IDLE start rules apply).
  - abort goes to IDLE.
- Priority within one cycle: abort > start > pause > tick_1s.
  - A pause coinciding with a tick drops the tick.
  - start in WORK/REST/PREP/PAUSED is ignored.
  - pause in IDLE/DONE is ignored.
- abort: next cycle phase=IDLE and all outputs take their reset values; the latched config is retained.
- Buzzer:
  - The beep counter is loaded with BEEP_SEC on every entry to WORK, REST or DONE.
  - Same-phase round rollover counts as an entry.
  - buzzer = synced 2 kHz level while beep counter>0.
  - The counter decrements on tick_1s.
  - The first beep second may be short because ticks are not aligned to phase entry.
- Arithmetic: counters are unsigned; decrement happens only when the value is >1, so there is no underflow. round_idx never exceeds num_rounds.

Optional Feature:
- Macro: INTERVAL_PREP_EN.
- Defined:
  - A valid start enters PREP with sec_left=3 and round_idx=0.
  - PREP counts down like WORK, then enters WORK with round_idx=1.
  - The buzzer beeps on PREP entry.
  - PREP can be paused.
- Undefined: the PREP state and its logic are absent; start goes directly to WORK. Encoding 1 is unused.

Decomposition:
- Package interval_pkg holds:
  - the phase enum/localparams (IDLE..DONE, 3 bits);
  - PREP_SEC=3;
  - default SEC_W/ROUND_W.
- One sub-module, level_edge_sync: 2-flop synchronizer plus rising-edge pulse, with sync active-low reset. It is instantiated for the 1 Hz path; the 2 kHz path uses its synced level output.

Test Plan:
- work=3, rest=2, rounds=2, start → WORK 3,2,1 → REST 2,1 → WORK round 2 3,2,1 → DONE after 8 ticks; done high exactly 1 cycle.
- work=2, rest=0, rounds=3 → WORK rounds 1,2,3 back to back, sec_left 2,1 each; DONE after 6 ticks; no REST ever seen.
- In WORK at sec_left=2, pause pulse, then 5 ticks → phase=4, sec_left=2, buzzer=0; pause again → WORK, next tick gives sec_left=1.
- abort asserted in the same cycle as tick_1s during REST → next cycle phase=0, sec_left=0, round_idx=0, buzzer=0, done=0.
- start with work_sec=0 (then with num_rounds=0) → phase stays 0, no tick changes any output.
- WORK entry with BEEP_SEC=1 and clk_2khz toggling → buzzer follows the synced 2 kHz level until the next tick, then 0. With INTERVAL_PREP_EN: start → PREP 3,2,1, then WORK round 1.
